// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory controller for RV64 loads/stores.
// Valid/ready request and response handshakes, configurable access latency,
// and fault reporting for misaligned, out-of-range and illegal accesses.
module dmem_ctrl #(
  parameter int unsigned XLEN       = 64,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 20,
  parameter int unsigned LATENCY    = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_store_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_fault_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned NumBytes = XLEN / 8;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                store_q;
  logic [2:0]          funct3_q;
  logic [XLEN-1:0]     addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic [XLEN-1:0]     rdata_q;
  logic                fault_q;

  logic [7:0]          mem [Depth];

  logic                accept;
  logic                commit;
  logic [3:0]          nbytes;
  logic [XLEN-1:0]     offset;
  logic [XLEN:0]       last_byte;
  logic                range_fault;
  logic                align_fault;
  logic                illegal;
  logic                fault;
  logic [DEPTH_LOG2-1:0] idx;
  logic [XLEN-1:0]     raw;
  logic [XLEN-1:0]     ext;

  assign accept       = (state_q == StIdle) && req_valid_i;
  assign commit       = (state_q == StBusy) && (cnt_q == '0);
  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_rdata_o = rdata_q;
  assign resp_fault_o = fault_q;

  // Access decode from the captured request: size, offset and fault sources.
  always_comb begin
    nbytes = 4'd1;
    align_fault = 1'b0;
    unique case (funct3_q[1:0])
      2'd0: begin nbytes = 4'd1; align_fault = 1'b0;            end
      2'd1: begin nbytes = 4'd2; align_fault = addr_q[0];       end
      2'd2: begin nbytes = 4'd4; align_fault = |addr_q[1:0];    end
      default: begin nbytes = 4'd8; align_fault = |addr_q[2:0]; end
    endcase
    offset = addr_q - BASE_ADDR[XLEN-1:0];
    // One extra bit so an offset near the top of the address space cannot wrap into range.
    last_byte   = {1'b0, offset} + {{(XLEN-3){1'b0}}, nbytes} - {{XLEN{1'b0}}, 1'b1};
    range_fault = |last_byte[XLEN:DEPTH_LOG2];
    illegal     = store_q ? funct3_q[2] : (funct3_q == 3'b111);
    fault       = range_fault | align_fault | illegal;
    idx         = offset[DEPTH_LOG2-1:0];
  end

  // Little-endian gather of the addressed bytes; bytes beyond the access size read as 0.
  always_comb begin
    raw = '0;
    for (int i = 0; i < NumBytes; i++) begin
      if (4'(i) < nbytes) begin
        raw[8*i +: 8] = mem[idx + DEPTH_LOG2'(i)];
      end
    end
  end

  // Sign or zero extension selected by funct3.
  always_comb begin
    ext = '0;
    case (funct3_q)
      3'b000:  ext = {{(XLEN-8){raw[7]}}, raw[7:0]};
      3'b001:  ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
      3'b010:  ext = {{(XLEN-32){raw[31]}}, raw[31:0]};
      3'b011:  ext = raw;
      3'b100:  ext = {{(XLEN-8){1'b0}}, raw[7:0]};
      3'b101:  ext = {{(XLEN-16){1'b0}}, raw[15:0]};
      3'b110:  ext = {{(XLEN-32){1'b0}}, raw[31:0]};
      default: ext = '0;
    endcase
  end

  // Next-state logic: IDLE accepts, BUSY counts down the latency, RESP waits for the consumer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          state_d = StBusy;
          cnt_d   = CntW'(LATENCY - 1);
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture on accept; later changes on req_* do not affect the access.
  always_ff @(posedge clock) begin
    if (reset) begin
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      store_q  <= req_store_i;
      funct3_q <= req_funct3_i;
      addr_q   <= req_addr_i;
      wdata_q  <= req_wdata_i;
    end
  end

  // Store commit on the BUSY->RESP edge; reset before this edge cancels the write.
  always_ff @(posedge clock) begin
    if (!reset && commit && store_q && !fault) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (4'(i) < nbytes) begin
          mem[idx + DEPTH_LOG2'(i)] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  // Response registers, loaded on commit and held through RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else if (commit) begin
      fault_q <= fault;
      rdata_q <= (store_q || fault) ? '0 : ext;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: three instances at LATENCY 1, 4 and 3 share the request
// bus; only the selected instance sees req_valid, and its outputs are observed.
module tb_dmem_ctrl;

  localparam logic [63:0] Base = 64'h8000_0000;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_ready;
  int          sel;

  logic        ready_w [3];
  logic        valid_w [3];
  logic [63:0] rdata_w [3];
  logic        fault_w [3];

  logic        obs_ready;
  logic        obs_valid;
  logic [63:0] obs_rdata;
  logic        obs_fault;

  int checks;
  int failures;

  dmem_ctrl #(.LATENCY(1)) u_lat1 (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid && sel == 0), .req_ready_o(ready_w[0]),
    .req_store_i(req_store), .req_funct3_i(req_funct3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(valid_w[0]), .resp_ready_i(resp_ready),
    .resp_rdata_o(rdata_w[0]), .resp_fault_o(fault_w[0])
  );

  dmem_ctrl #(.LATENCY(4)) u_lat4 (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid && sel == 1), .req_ready_o(ready_w[1]),
    .req_store_i(req_store), .req_funct3_i(req_funct3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(valid_w[1]), .resp_ready_i(resp_ready),
    .resp_rdata_o(rdata_w[1]), .resp_fault_o(fault_w[1])
  );

  dmem_ctrl #(.LATENCY(3)) u_lat3 (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid && sel == 2), .req_ready_o(ready_w[2]),
    .req_store_i(req_store), .req_funct3_i(req_funct3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(valid_w[2]), .resp_ready_i(resp_ready),
    .resp_rdata_o(rdata_w[2]), .resp_fault_o(fault_w[2])
  );

  always_comb begin
    obs_ready = ready_w[sel];
    obs_valid = valid_w[sel];
    obs_rdata = rdata_w[sel];
    obs_fault = fault_w[sel];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input string what, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  // One transaction with resp_ready held high; lat counts edges from accept to resp_valid.
  task automatic xact(input logic st, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] wd, output logic [63:0] rd, output logic flt,
                      output int lat);
    int n;
    @(negedge clock);
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    resp_ready = 1'b1;
    n = 0;
    while (!obs_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_addr  = ~a;
    req_wdata = ~wd;
    req_store = ~st;
    lat = 0;
    while (!obs_valid && lat < 50) begin
      @(posedge clock);
      #1;
      lat++;
    end
    rd  = obs_rdata;
    flt = obs_fault;
    @(posedge clock);
    #1;
  endtask

  task automatic run(input string tag, input logic st, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] wd, input logic [63:0] exp_rd,
                     input logic exp_flt, input int exp_lat);
    logic [63:0] rd;
    logic        flt;
    int          lat;
    xact(st, f3, a, wd, rd, flt, lat);
    chk(tag, "rdata", rd, exp_rd);
    chk(tag, "fault", {63'd0, flt}, {63'd0, exp_flt});
    chk(tag, "latency", 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    logic [63:0] held;
    int n_acc;
    int n_rsp;
    int last_acc;
    int n;
    checks     = 0;
    failures   = 0;
    sel        = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("reset", "req_ready", {63'd0, ready_w[k]}, 64'd1);
      chk("reset", "resp_valid", {63'd0, valid_w[k]}, 64'd0);
      chk("reset", "rdata", rdata_w[k], 64'd0);
      chk("reset", "fault", {63'd0, fault_w[k]}, 64'd0);
    end

    // Doubleword store/load round trip at LATENCY=1.
    run("sd", 1, 3'b011, Base + 64'h8, 64'h1122334455667788, 64'd0, 0, 1);
    run("ld", 0, 3'b011, Base + 64'h8, 64'd0, 64'h1122334455667788, 0, 1);

    // Sub-word stores and sign/zero extension.
    run("sd0", 1, 3'b011, Base + 64'h10, 64'd0, 64'd0, 0, 1);
    run("sb", 1, 3'b000, Base + 64'h10, 64'hFFFF_FFFF_FFFF_FF80, 64'd0, 0, 1);
    run("lb", 0, 3'b000, Base + 64'h10, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 0, 1);
    run("lbu", 0, 3'b100, Base + 64'h10, 64'd0, 64'h80, 0, 1);
    run("sh", 1, 3'b001, Base + 64'h12, 64'h1234_5678_9ABC_BEEF, 64'd0, 0, 1);
    run("lw", 0, 3'b010, Base + 64'h10, 64'd0, 64'hFFFF_FFFF_BEEF_0080, 0, 1);
    run("lwu", 0, 3'b110, Base + 64'h10, 64'd0, 64'h0000_0000_BEEF_0080, 0, 1);
    run("lh", 0, 3'b001, Base + 64'h12, 64'd0, 64'hFFFF_FFFF_FFFF_BEEF, 0, 1);
    run("lhu", 0, 3'b101, Base + 64'h12, 64'd0, 64'h0000_0000_0000_BEEF, 0, 1);

    // Faults: misalignment, range, wrap below base, illegal funct3; array untouched.
    run("lw_mis", 0, 3'b010, Base + 64'h2, 64'd0, 64'd0, 1, 1);
    run("sw_top", 1, 3'b010, Base + 64'hF_FFFC, 64'h1234_5678, 64'd0, 0, 1);
    run("sd_top", 1, 3'b011, Base + 64'hF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 1);
    run("lw_top", 0, 3'b010, Base + 64'hF_FFFC, 64'd0, 64'h1234_5678, 0, 1);
    run("ld_oor", 0, 3'b011, Base + 64'h10_0000, 64'd0, 64'd0, 1, 1);
    run("lb_low", 0, 3'b000, Base - 64'h1, 64'd0, 64'd0, 1, 1);
    run("sbu_ill", 1, 3'b100, Base + 64'h10, 64'h11, 64'd0, 1, 1);
    run("lbu_aft", 0, 3'b100, Base + 64'h10, 64'd0, 64'h80, 0, 1);
    run("l111", 0, 3'b111, Base + 64'h8, 64'd0, 64'd0, 1, 1);

    // LATENCY=4 with a stalled consumer.
    sel = 1;
    run("sd4", 1, 3'b011, Base + 64'h40, 64'hCAFE_F00D_1234_5678, 64'd0, 0, 4);
    @(negedge clock);
    req_store  = 1'b0;
    req_funct3 = 3'b011;
    req_addr   = Base + 64'h40;
    req_valid  = 1'b1;
    resp_ready = 1'b0;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!obs_valid && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("ld4", "latency", 64'(n), 64'd4);
    held = obs_rdata;
    chk("ld4", "rdata", held, 64'hCAFE_F00D_1234_5678);
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      chk("stall", "resp_valid", {63'd0, obs_valid}, 64'd1);
      chk("stall", "rdata", obs_rdata, 64'hCAFE_F00D_1234_5678);
      chk("stall", "fault", {63'd0, obs_fault}, 64'd0);
      chk("stall", "req_ready", {63'd0, obs_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("release", "resp_valid", {63'd0, obs_valid}, 64'd0);
    chk("release", "req_ready", {63'd0, obs_ready}, 64'd1);

    // LATENCY=3: reset during BUSY cancels the store.
    sel = 2;
    run("sb3", 1, 3'b000, Base + 64'h30, 64'h55, 64'd0, 0, 3);
    @(negedge clock);
    req_store  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = Base + 64'h30;
    req_wdata  = 64'hAA;
    req_valid  = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_busy", "resp_valid", {63'd0, obs_valid}, 64'd0);
    chk("rst_busy", "req_ready", {63'd0, obs_ready}, 64'd1);
    repeat (4) @(posedge clock);
    run("lbu3", 0, 3'b100, Base + 64'h30, 64'd0, 64'h55, 0, 3);

    // Back-to-back requests at LATENCY=1 with req_valid held high.
    sel = 0;
    run("sd_b2b", 1, 3'b011, Base + 64'h50, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 1);
    @(negedge clock);
    req_store  = 1'b0;
    req_funct3 = 3'b011;
    req_addr   = Base + 64'h50;
    req_valid  = 1'b1;
    resp_ready = 1'b1;
    n_acc    = 0;
    n_rsp    = 0;
    last_acc = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (cyc != 0) @(negedge clock);
      if (n_acc == 10) req_valid = 1'b0;
      if (obs_ready && req_valid) begin
        if (n_acc > 0) chk("b2b", "spacing", 64'(cyc - last_acc), 64'd3);
        last_acc = cyc;
        n_acc++;
      end
      if (obs_valid) begin
        n_rsp++;
        chk("b2b", "rdata", obs_rdata, 64'h0123_4567_89AB_CDEF);
      end
    end
    chk("b2b", "accepts", 64'(n_acc), 64'd10);
    chk("b2b", "responses", 64'(n_rsp), 64'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
